// File: rtl/proc_mem_pkg.sv
// Shared types and helpers for the fetch/memory-stage RAM arbitration path.
package proc_mem_pkg;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned WORD_BYTES = 8;
    localparam int unsigned ADDR_X_W   = WORD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mem_state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    // True when a full word at addr would run past the end of RAM; one extra bit so no wrap.
    function automatic logic addr_fault(input logic [WORD_W-1:0] addr,
                                        input int unsigned       mem_bytes);
        logic [ADDR_X_W-1:0] end_addr;
        end_addr = {1'b0, addr} + ADDR_X_W'(WORD_BYTES);
        return end_addr > ADDR_X_W'(mem_bytes);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests with a fetch-starvation bound.
module mem_arb_pick #(
    parameter int unsigned FAIR_MAX = 4,
    parameter int unsigned STREAK_W = 3
) (
    input  logic                if_req,
    input  logic                dm_req,
    input  logic [STREAK_W-1:0] dm_streak,
    output logic                grant_valid,
    output logic                grant_dm
);

    // Data side wins ties until it has taken FAIR_MAX grants in a row over a waiting fetch.
    always_comb begin
        grant_valid = if_req | dm_req;
        grant_dm    = dm_req & (~if_req | (dm_streak != STREAK_W'(FAIR_MAX)));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port RAM between the fetch and memory stages.
module mem_arbiter
    import proc_mem_pkg::*;
#(
    parameter int unsigned MEM_LAT   = 2,
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned FAIR_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_done,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [WORD_W-1:0] dm_addr,
    input  logic [WORD_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [WORD_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned LAT_W    = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam int unsigned STREAK_W = (FAIR_MAX < 2) ? 1 : $clog2(FAIR_MAX + 1);

    mem_state_e          state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                we_q, we_d;
    logic [WORD_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic                if_done_q, if_done_d;
    logic [WORD_W-1:0]   if_rdata_q, if_rdata_d;
    logic                if_err_q, if_err_d;
    logic                dm_done_q, dm_done_d;
    logic [WORD_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                dm_err_q, dm_err_d;
    logic                busy_q, busy_d;
    logic                owner_q, owner_d;

    logic                grant_valid;
    logic                grant_dm;
    logic [WORD_W-1:0]   sel_addr;
    logic [WORD_W-1:0]   resp_rdata;

    mem_arb_pick #(
        .FAIR_MAX (FAIR_MAX),
        .STREAK_W (STREAK_W)
    ) u_pick (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .dm_streak   (streak_q),
        .grant_valid (grant_valid),
        .grant_dm    (grant_dm)
    );

    // Next-state, request latch, fairness streak and registered response outputs.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        streak_d    = streak_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        if_done_d   = 1'b0;
        if_rdata_d  = '0;
        if_err_d    = 1'b0;
        dm_done_d   = 1'b0;
        dm_rdata_d  = '0;
        dm_err_d    = 1'b0;
        sel_addr    = grant_dm ? dm_addr : if_addr;
        resp_rdata  = we_q ? '0 : mem_rdata;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d     = grant_dm ? OWNER_DM : OWNER_IF;
                    mem_addr_d  = sel_addr;
                    we_d        = grant_dm & dm_we;
                    mem_wdata_d = grant_dm ? dm_wdata : '0;
                    // A data grant over a waiting fetch can only happen below FAIR_MAX.
                    if (!grant_dm) begin
                        streak_d = '0;
                    end else if (if_req) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                    if (addr_fault(sel_addr, MEM_BYTES)) begin
                        state_d = ST_RESP;
                        if (grant_dm) begin
                            dm_done_d = 1'b1;
                            dm_err_d  = 1'b1;
                        end else begin
                            if_done_d = 1'b1;
                            if_err_d  = 1'b1;
                        end
                    end else begin
                        state_d  = ST_ACCESS;
                        lat_d    = LAT_W'(1);
                        mem_en_d = 1'b1;
                        mem_we_d = grant_dm & dm_we;
                    end
                end
            end
            ST_ACCESS: begin
                if (lat_q == LAT_W'(MEM_LAT)) begin
                    state_d = ST_RESP;
                    lat_d   = '0;
                    if (owner_q == OWNER_DM) begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = resp_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = resp_rdata;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            streak_q    <= '0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            dm_done_q   <= 1'b0;
            dm_rdata_q  <= '0;
            dm_err_q    <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            streak_q    <= streak_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            if_done_q   <= if_done_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            dm_done_q   <= dm_done_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_err_q    <= dm_err_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign dm_done   = dm_done_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_err    = dm_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, word-level reference model, scenario tasks.
module tb_mem_arbiter;
    import proc_mem_pkg::*;

    localparam int unsigned MEM_LAT   = 2;
    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned FAIR_MAX  = 4;
    localparam int unsigned WORDS     = MEM_BYTES / 8;
    localparam int unsigned IDX_W     = $clog2(WORDS);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_done;
    logic [63:0] if_rdata;
    logic        if_err;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic        dm_done;
    logic [63:0] dm_rdata;
    logic        dm_err;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        busy;
    logic        owner;

    int checks = 0;
    int errors = 0;

    logic [63:0] ram       [WORDS];
    logic [63:0] model_mem [WORDS];
    int          model_streak = 0;

    int          en_cnt = 0;
    logic [63:0] en_addr = '0;
    logic        en_we = 1'b0;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .MEM_BYTES(MEM_BYTES), .FAIR_MAX(FAIR_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears one edge after the strobe and holds until the next read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[IDX_W+2:3]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[IDX_W+2:3]];
        end
    end

    // Record every RAM strobe seen by the RAM.
    always @(posedge clk) begin
        if (mem_en) begin
            en_cnt  = en_cnt + 1;
            en_addr = mem_addr;
            en_we   = mem_we;
        end
    end

    // Response outputs must be quiet without done, and the two dones never overlap.
    always @(negedge clk) begin
        if (!rst) begin
            checks = checks + 1;
            if ((!if_done && (if_rdata !== 64'd0 || if_err !== 1'b0)) ||
                (!dm_done && (dm_rdata !== 64'd0 || dm_err !== 1'b0)) ||
                (if_done && dm_done) || (mem_we && !mem_en)) begin
                errors = errors + 1;
                $display("FAIL idle_outputs t=%0t if_done=%b if_rdata=%h if_err=%b dm_done=%b dm_rdata=%h dm_err=%b mem_en=%b mem_we=%b (required quiet outputs)",
                         $time, if_done, if_rdata, if_err, dm_done, dm_rdata, dm_err, mem_en, mem_we);
            end
        end
    end

    function automatic int unsigned widx(input logic [63:0] a);
        return int'(a[IDX_W+2:3]);
    endfunction

    // Reference model of one transaction from the address-map and latency rules.
    task automatic model_txn(input bit is_dm, input bit we, input logic [63:0] addr,
                             input logic [63:0] wdata, output logic [63:0] exp_rdata,
                             output logic exp_err, output int exp_lat, output int exp_en);
        logic [64:0] end_addr;
        end_addr  = {1'b0, addr} + 65'd8;
        exp_rdata = '0;
        if (!is_dm) model_streak = 0;
        if (end_addr > 65'(MEM_BYTES)) begin
            exp_err = 1'b1;
            exp_lat = 1;
            exp_en  = 0;
        end else begin
            exp_err = 1'b0;
            exp_lat = MEM_LAT + 1;
            exp_en  = 1;
            if (is_dm && we) model_mem[widx(addr)] = wdata;
            else             exp_rdata = model_mem[widx(addr)];
        end
    endtask

    // Issue one request from an idle arbiter and wait (bounded) for its done pulse.
    task automatic do_txn(input bit is_dm, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rdata,
                          output logic err, output int lat);
        bit got;
        @(negedge clk);
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        got = 1'b0; lat = 0; rdata = '0; err = 1'b0;
        while (!got && lat < 64) begin
            @(negedge clk);
            lat = lat + 1;
            if (is_dm ? dm_done : if_done) begin
                got   = 1'b1;
                rdata = is_dm ? dm_rdata : if_rdata;
                err   = is_dm ? dm_err : if_err;
            end
        end
        if (!got) lat = -1;
        if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if ({if_done, if_err, dm_done, dm_err, mem_en, mem_we, busy, owner} !== 8'd0 ||
            if_rdata !== 64'd0 || dm_rdata !== 64'd0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs flags=%b mem_addr=%h mem_wdata=%h required all zero",
                     {if_done, if_err, dm_done, dm_err, mem_en, mem_we, busy, owner}, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        model_streak = 0;
    endtask

    task automatic test_fetch_read();
        logic [63:0] r, er; logic e, ee; int l, el, en, e0;
        e0 = en_cnt;
        model_txn(1'b0, 1'b0, 64'h40, '0, er, ee, el, en);
        do_txn(1'b0, 1'b0, 64'h40, '0, r, e, l);
        checks = checks + 4;
        if (l !== el)  begin errors++; $display("FAIL fetch_latency got %0d required %0d", l, el); end
        if (r !== er)  begin errors++; $display("FAIL fetch_rdata got %h required %h", r, er); end
        if (e !== ee)  begin errors++; $display("FAIL fetch_err got %b required %b", e, ee); end
        if (en_cnt - e0 !== en || en_addr !== 64'h40 || en_we !== 1'b0) begin
            errors++;
            $display("FAIL fetch_strobe count=%0d addr=%h we=%b required count=%0d addr=40 we=0",
                     en_cnt - e0, en_addr, en_we, en);
        end
    endtask

    task automatic test_data_write();
        logic [63:0] r, er; logic e, ee; int l, el, en, e0;
        e0 = en_cnt;
        model_txn(1'b1, 1'b1, 64'h100, 64'hDEADBEEF, er, ee, el, en);
        do_txn(1'b1, 1'b1, 64'h100, 64'hDEADBEEF, r, e, l);
        checks = checks + 3;
        if (l !== el || e !== ee) begin errors++; $display("FAIL write_resp lat=%0d err=%b required lat=%0d err=%b", l, e, el, ee); end
        if (r !== 64'd0) begin errors++; $display("FAIL write_rdata got %h required 0", r); end
        if (en_cnt - e0 !== 1 || en_we !== 1'b1 || en_addr !== 64'h100) begin
            errors++;
            $display("FAIL write_strobe count=%0d we=%b addr=%h required 1/1/100", en_cnt - e0, en_we, en_addr);
        end
        model_txn(1'b1, 1'b0, 64'h100, '0, er, ee, el, en);
        do_txn(1'b1, 1'b0, 64'h100, '0, r, e, l);
        checks = checks + 1;
        if (r !== 64'hDEADBEEF || r !== er) begin errors++; $display("FAIL write_readback got %h required %h", r, er); end
    endtask

    task automatic test_fault();
        logic [63:0] addrs [4];
        logic [63:0] r, er; logic e, ee; int l, el, en, e0;
        addrs[0] = 64'h3FC; addrs[1] = 64'hFFFF_FFFF_FFFF_FFFC; addrs[2] = 64'h3F8; addrs[3] = 64'h400;
        for (int i = 0; i < 4; i++) begin
            bit is_dm;
            is_dm = (i != 3);
            e0 = en_cnt;
            model_txn(is_dm, 1'b0, addrs[i], '0, er, ee, el, en);
            do_txn(is_dm, 1'b0, addrs[i], '0, r, e, l);
            checks = checks + 1;
            if (l !== el || e !== ee || r !== er || en_cnt - e0 !== en) begin
                errors++;
                $display("FAIL fault_%0d addr=%h lat=%0d err=%b rdata=%h strobes=%0d required lat=%0d err=%b rdata=%h strobes=%0d",
                         i, addrs[i], l, e, r, en_cnt - e0, el, ee, er, en);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, w, r, er; logic e, ee; int l, el, en, e0; bit is_dm, we;
        for (int i = 0; i < 24; i++) begin
            is_dm = 1'($urandom_range(0, 1));
            we    = is_dm & 1'($urandom_range(0, 1));
            w     = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) a = 64'(MEM_BYTES) - 64'($urandom_range(1, 7)) + 64'($urandom_range(0, 64));
            else                           a = 64'($urandom_range(0, WORDS - 1)) << 3;
            e0 = en_cnt;
            model_txn(is_dm, we, a, w, er, ee, el, en);
            do_txn(is_dm, we, a, w, r, e, l);
            checks = checks + 1;
            if (l !== el || e !== ee || r !== er || en_cnt - e0 !== en ||
                (en == 1 && (en_addr !== a || en_we !== we))) begin
                errors++;
                $display("FAIL random_%0d dm=%b we=%b addr=%h lat=%0d err=%b rdata=%h strobes=%0d required lat=%0d err=%b rdata=%h strobes=%0d",
                         i, is_dm, we, a, l, e, r, en_cnt - e0, el, ee, er, en);
            end
        end
    endtask

    task automatic test_back_to_back();
        int grants, cyc, gap;
        bit exp_dm;
        logic [63:0] exp_r;
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h80;
        grants = 0; cyc = 0; gap = 0;
        while (grants < 12 && cyc < 200) begin
            @(negedge clk);
            cyc++; gap++;
            if (if_done || dm_done) begin
                if (model_streak == FAIR_MAX) begin exp_dm = 1'b0; model_streak = 0; end
                else begin exp_dm = 1'b1; model_streak++; end
                exp_r = exp_dm ? model_mem[widx(64'h80)] : model_mem[widx(64'h40)];
                checks = checks + 1;
                if (dm_done !== exp_dm || (exp_dm ? dm_rdata : if_rdata) !== exp_r ||
                    (grants > 0 && gap !== MEM_LAT + 2)) begin
                    errors++;
                    $display("FAIL contention_grant_%0d dm_done=%b if_done=%b gap=%0d required dm=%b gap=%0d data=%h",
                             grants, dm_done, if_done, gap, exp_dm, MEM_LAT + 2, exp_r);
                end
                grants++; gap = 0;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        checks = checks + 1;
        if (grants !== 12) begin errors++; $display("FAIL contention_count got %0d grants required 12", grants); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r, er; logic e, ee; int l, el, en, stray;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; dm_req = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if ({if_done, dm_done, mem_en, mem_we, busy, owner} !== 6'd0 || mem_addr !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs flags=%b mem_addr=%h required zero", {if_done, dm_done, mem_en, mem_we, busy, owner}, mem_addr);
        end
        rst = 1'b0;
        model_streak = 0;
        stray = 0;
        repeat (5) begin @(negedge clk); if (if_done || dm_done || busy) stray++; end
        checks = checks + 1;
        if (stray !== 0) begin errors++; $display("FAIL reset_mid_stray got %0d active cycles required 0", stray); end
        model_txn(1'b0, 1'b0, 64'h40, '0, er, ee, el, en);
        do_txn(1'b0, 1'b0, 64'h40, '0, r, e, l);
        checks = checks + 1;
        if (l !== el || r !== er || e !== ee) begin
            errors++;
            $display("FAIL reset_mid_refetch lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b", l, r, e, el, er, ee);
        end
    endtask

    task automatic test_dm_during_fetch();
        logic [63:0] er_if, er_dm; logic ee; int el, en, cyc, t, idle;
        bit got;
        model_txn(1'b0, 1'b0, 64'h80, '0, er_if, ee, el, en);
        model_txn(1'b1, 1'b0, 64'h100, '0, er_dm, ee, el, en);
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h80;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h100;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 20) begin
            if (if_done) got = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
        checks = checks + 1;
        if (!got || if_rdata !== er_if || owner !== OWNER_IF || dm_done !== 1'b0) begin
            errors++;
            $display("FAIL overlap_fetch done=%b rdata=%h owner=%b required done=1 rdata=%h owner=0", got, if_rdata, owner, er_if);
        end
        if_req = 1'b0;
        got = 1'b0; t = 0; idle = 0;
        while (!got && t < 20) begin
            @(negedge clk);
            t++;
            if (!busy) idle++;
            if (t == 2) begin
                checks = checks + 1;
                if (owner !== OWNER_DM || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL overlap_owner owner=%b busy=%b required owner=1 busy=1", owner, busy);
                end
            end
            if (dm_done) got = 1'b1;
        end
        dm_req = 1'b0;
        checks = checks + 2;
        if (idle !== 1) begin errors++; $display("FAIL overlap_idle got %0d idle cycles required 1", idle); end
        if (t !== MEM_LAT + 2 || dm_rdata !== er_dm) begin
            errors++;
            $display("FAIL overlap_dm offset=%0d rdata=%h required offset=%0d rdata=%h", t, dm_rdata, MEM_LAT + 2, er_dm);
        end
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            logic [63:0] w;
            w = {$urandom, $urandom};
            ram[i]       = w;
            model_mem[i] = w;
        end
        test_reset();
        test_fetch_read();
        test_data_write();
        test_fault();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_dm_during_fetch();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
